// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for a 5-stage (F/D/E/M/W) pipeline. It
// sits beside the decode-stage control unit and drives the pipeline-register
// enables/clears and the ALU operand-select muxes.
//
// Functions:
//   - Three-source operand forwarding (E > M > W priority).
//   - Load-use stall of LOAD_USE_CYC bubbles, sequenced by a small counter.
//   - Memory-wait freeze while the data memory has not completed.
//   - Taken-branch (resolved in M) and jump (decoded in D) flushes.
//   - Saturating performance counter of stall/freeze cycles.
//
// Ports:
//   Clk, Clrn              clock (rising edge), async active-low reset
//   D_Rs/D_Rt/D_UseRs/Rt   source registers of the D-stage instruction
//   E_Rd/E_Wreg/E_Load     E-stage destination, write enable, load flag
//   M_Rd/M_Wreg/M_Mem      M-stage destination, write enable, memory access
//   W_Rd/W_Wreg            W-stage destination, write enable
//   Mem_Ready              data memory completes this cycle
//   Br_Taken, Jump         branch taken in M, jump decoded in D
//   Clr_Cnt                synchronous clear of Stall_Count
//   FwdA/FwdB              operand select: 00 regfile, 10 E, 01 M, 11 W
//   Stall_F, Bubble_E      hold PC + IF/ID, load NOP into ID/EX
//   Freeze                 hold all pipeline registers
//   Flush_D/E/M            clear IF/ID, ID/EX, EX/MEM
//   Stall_Count            saturating count of stall/freeze cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int REG_AW       = 5,
  parameter int LOAD_USE_CYC = 1,
  parameter int CNT_W        = 16
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic [REG_AW-1:0] D_Rs,
  input  logic [REG_AW-1:0] D_Rt,
  input  logic              D_UseRs,
  input  logic              D_UseRt,
  input  logic [REG_AW-1:0] E_Rd,
  input  logic              E_Wreg,
  input  logic              E_Load,
  input  logic [REG_AW-1:0] M_Rd,
  input  logic              M_Wreg,
  input  logic              M_Mem,
  input  logic [REG_AW-1:0] W_Rd,
  input  logic              W_Wreg,
  input  logic              Mem_Ready,
  input  logic              Br_Taken,
  input  logic              Jump,
  input  logic              Clr_Cnt,
  output logic [1:0]        FwdA,
  output logic [1:0]        FwdB,
  output logic              Stall_F,
  output logic              Bubble_E,
  output logic              Freeze,
  output logic              Flush_D,
  output logic              Flush_E,
  output logic              Flush_M,
  output logic [CNT_W-1:0]  Stall_Count
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_LDUSE = 1'b1
  } state_t;

  localparam logic [REG_AW-1:0] REG_ZERO  = '0;
  localparam logic [3:0]        LU_RELOAD = 4'(LOAD_USE_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_freeze;
  logic             w_hz;
  logic             w_stall;
  logic             w_flush_br;
  logic             w_flush_jmp;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // Operand select for one source register. The youngest producer wins.
  // A load in E is the youngest producer but its data is not ready; M or W
  // would hold a stale copy, so no forward is selected and the load-use
  // stall keeps the instruction in D until the value reaches M.
  function automatic logic [1:0] fwd_sel(
    input logic              use_x,
    input logic [REG_AW-1:0] src,
    input logic              e_wreg,
    input logic              e_load,
    input logic [REG_AW-1:0] e_rd,
    input logic              m_wreg,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_wreg,
    input logic [REG_AW-1:0] w_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_x && (src != REG_ZERO)) begin
      if (e_wreg && (e_rd == src)) begin
        sel = e_load ? 2'b00 : 2'b10;
      end else if (m_wreg && (m_rd == src)) begin
        sel = 2'b01;
      end else if (w_wreg && (w_rd == src)) begin
        sel = 2'b11;
      end else begin
        sel = 2'b00;
      end
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign w_fwd_a = fwd_sel(D_UseRs, D_Rs, E_Wreg, E_Load, E_Rd,
                           M_Wreg, M_Rd, W_Wreg, W_Rd);
  assign w_fwd_b = fwd_sel(D_UseRt, D_Rt, E_Wreg, E_Load, E_Rd,
                           M_Wreg, M_Rd, W_Wreg, W_Rd);

  assign w_freeze = M_Mem & ~Mem_Ready;

  assign w_hz = E_Load & E_Wreg & (E_Rd != REG_ZERO) &
                ((D_UseRs & (D_Rs == E_Rd)) | (D_UseRt & (D_Rt == E_Rd)));

  // Next-state and stall/flush decode. Freeze outranks everything and holds
  // the sequencer; a taken branch outranks any load-use stall.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_flush_br  = 1'b0;
    if (w_freeze) begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
    end else if (Br_Taken) begin
      w_flush_br  = 1'b1;
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = 4'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_hz) begin
            w_stall = 1'b1;
            // First bubble is issued here; the remaining ones come from LDUSE.
            if (LOAD_USE_CYC > 1) begin
              w_state_nxt = ST_LDUSE;
              w_cnt_nxt   = LU_RELOAD;
            end else begin
              w_state_nxt = ST_RUN;
              w_cnt_nxt   = 4'd0;
            end
          end else begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = r_cnt;
          end
        end
        ST_LDUSE: begin
          w_stall = 1'b1;
          if (r_cnt <= 4'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = ST_LDUSE;
            w_cnt_nxt   = r_cnt - 4'd1;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = 4'd0;
        end
      endcase
    end
  end

  // A jump held by a stall is flushed on the cycle the stall releases it.
  assign w_flush_jmp = Jump & ~Br_Taken & ~w_freeze & ~w_stall;

  // Load-use sequencer state and remaining-bubble counter.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_state <= ST_RUN;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Saturating stall/freeze cycle counter; clear outranks increment.
  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      r_stall_cnt <= CNT_ZERO;
    end else if (Clr_Cnt) begin
      r_stall_cnt <= CNT_ZERO;
    end else if ((w_stall | w_freeze) && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  // Combinational outputs read as 0 for the whole time reset is asserted.
  assign FwdA        = Clrn ? w_fwd_a : 2'b00;
  assign FwdB        = Clrn ? w_fwd_b : 2'b00;
  assign Stall_F     = Clrn & w_stall;
  assign Bubble_E    = Clrn & w_stall;
  assign Freeze      = Clrn & w_freeze;
  assign Flush_D     = Clrn & (w_flush_br | w_flush_jmp);
  assign Flush_E     = Clrn & w_flush_br;
  assign Flush_M     = Clrn & w_flush_br;
  assign Stall_Count = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic       Clk;
  logic       Clrn;
  logic [4:0] D_Rs, D_Rt, E_Rd, M_Rd, W_Rd;
  logic       D_UseRs, D_UseRt, E_Wreg, E_Load, M_Wreg, M_Mem, W_Wreg;
  logic       Mem_Ready, Br_Taken, Jump, Clr_Cnt;

  // Instance A: 3 bubbles per load-use, 4-bit counter.
  logic [1:0] a_fwda, a_fwdb;
  logic       a_stall, a_bubble, a_freeze, a_fd, a_fe, a_fm;
  logic [3:0] a_cnt;
  // Instance B: 1 bubble per load-use, 16-bit counter.
  logic [1:0]  b_fwda, b_fwdb;
  logic        b_stall, b_bubble, b_freeze, b_fd, b_fe, b_fm;
  logic [15:0] b_cnt;

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_USE_CYC(3), .CNT_W(4)) u_dut_a (
    .Clk(Clk), .Clrn(Clrn), .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRs(D_UseRs),
    .D_UseRt(D_UseRt), .E_Rd(E_Rd), .E_Wreg(E_Wreg), .E_Load(E_Load),
    .M_Rd(M_Rd), .M_Wreg(M_Wreg), .M_Mem(M_Mem), .W_Rd(W_Rd),
    .W_Wreg(W_Wreg), .Mem_Ready(Mem_Ready), .Br_Taken(Br_Taken),
    .Jump(Jump), .Clr_Cnt(Clr_Cnt), .FwdA(a_fwda), .FwdB(a_fwdb),
    .Stall_F(a_stall), .Bubble_E(a_bubble), .Freeze(a_freeze),
    .Flush_D(a_fd), .Flush_E(a_fe), .Flush_M(a_fm), .Stall_Count(a_cnt));

  pipe_hazard_ctrl #(.REG_AW(5), .LOAD_USE_CYC(1), .CNT_W(16)) u_dut_b (
    .Clk(Clk), .Clrn(Clrn), .D_Rs(D_Rs), .D_Rt(D_Rt), .D_UseRs(D_UseRs),
    .D_UseRt(D_UseRt), .E_Rd(E_Rd), .E_Wreg(E_Wreg), .E_Load(E_Load),
    .M_Rd(M_Rd), .M_Wreg(M_Wreg), .M_Mem(M_Mem), .W_Rd(W_Rd),
    .W_Wreg(W_Wreg), .Mem_Ready(Mem_Ready), .Br_Taken(Br_Taken),
    .Jump(Jump), .Clr_Cnt(Clr_Cnt), .FwdA(b_fwda), .FwdB(b_fwdb),
    .Stall_F(b_stall), .Bubble_E(b_bubble), .Freeze(b_freeze),
    .Flush_D(b_fd), .Flush_E(b_fe), .Flush_M(b_fm), .Stall_Count(b_cnt));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: bubbles still owed per instance, and the stall counter.
  int   lcyc[2] = '{3, 1};
  int   cmax[2] = '{15, 65535};
  int   m_left[2];
  int   m_cnt[2];
  logic exp_stall[2];
  logic exp_fz;
  logic m_hz;

  logic [10:0] act_vec[2];
  logic [31:0] act_cnt[2];
  always_comb begin
    act_vec[0] = {a_fwda, a_fwdb, a_stall, a_bubble, a_freeze, a_fd, a_fe, a_fm};
    act_vec[1] = {b_fwda, b_fwdb, b_stall, b_bubble, b_freeze, b_fd, b_fe, b_fm};
    act_cnt[0] = 32'(a_cnt);
    act_cnt[1] = 32'(b_cnt);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Newest writer of the register supplies it; a load still in E cannot.
  function automatic logic [1:0] ref_fwd(input logic use_x, input logic [4:0] r);
    logic [4:0] rd[3];
    logic       wr[3];
    logic [1:0] code[3];
    rd = '{E_Rd, M_Rd, W_Rd};
    wr = '{E_Wreg, M_Wreg, W_Wreg};
    code = '{2'b10, 2'b01, 2'b11};
    if (!use_x || r == 5'd0) return 2'b00;
    for (int i = 0; i < 3; i++) begin
      if (wr[i] && rd[i] == r) return (i == 0 && E_Load) ? 2'b00 : code[i];
    end
    return 2'b00;
  endfunction

  function automatic logic ref_hz();
    return E_Load && E_Wreg && (E_Rd != 5'd0) &&
           ((D_UseRs && D_Rs == E_Rd) || (D_UseRt && D_Rt == E_Rd));
  endfunction

  // Let inputs settle, then compare every output of both DUTs to the model.
  task automatic settle();
    logic       br, st, fd;
    logic [1:0] fa, fb;
    logic [10:0] ev;
    #1;
    if (!Clrn) begin
      for (int k = 0; k < 2; k++) begin m_left[k] = 0; m_cnt[k] = 0; end
    end
    exp_fz = M_Mem && !Mem_Ready;
    br     = Br_Taken && !exp_fz;
    m_hz   = ref_hz();
    fa     = ref_fwd(D_UseRs, D_Rs);
    fb     = ref_fwd(D_UseRt, D_Rt);
    for (int k = 0; k < 2; k++) begin
      st = !exp_fz && !br && (m_left[k] > 0 || m_hz);
      fd = br || (Jump && !Br_Taken && !exp_fz && !st);
      exp_stall[k] = st;
      ev = Clrn ? {fa, fb, st, st, exp_fz, fd, br, br} : 11'd0;
      chk(k == 0 ? "outs_a" : "outs_b", 32'(act_vec[k]), 32'(ev));
      chk(k == 0 ? "count_a" : "count_b", act_cnt[k], 32'(m_cnt[k]));
    end
  endtask

  // Advance one clock and update the model's owed bubbles and counter.
  task automatic tick();
    @(posedge Clk);
    if (Clrn) begin
      for (int k = 0; k < 2; k++) begin
        if (Clr_Cnt) m_cnt[k] = 0;
        else if ((exp_stall[k] || exp_fz) && m_cnt[k] < cmax[k]) m_cnt[k]++;
        if (exp_fz) begin
        end else if (Br_Taken) m_left[k] = 0;
        else if (m_left[k] > 0) m_left[k]--;
        else if (m_hz) m_left[k] = lcyc[k] - 1;
      end
    end
    @(negedge Clk);
  endtask

  task automatic idle_inputs();
    Clrn = 1'b1; D_Rs = 5'd0; D_Rt = 5'd0; D_UseRs = 1'b0; D_UseRt = 1'b0;
    E_Rd = 5'd0; E_Wreg = 1'b0; E_Load = 1'b0; M_Rd = 5'd0; M_Wreg = 1'b0;
    M_Mem = 1'b0; W_Rd = 5'd0; W_Wreg = 1'b0; Mem_Ready = 1'b1;
    Br_Taken = 1'b0; Jump = 1'b0; Clr_Cnt = 1'b0;
  endtask

  // Drain any pending stall, then clear the counters.
  task automatic drain_clear();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin settle(); tick(); end
    Clr_Cnt = 1'b1; settle(); tick();
    Clr_Cnt = 1'b0;
  endtask

  task automatic load_use_rt3();
    idle_inputs();
    E_Load = 1'b1; E_Wreg = 1'b1; E_Rd = 5'd3; D_Rt = 5'd3; D_UseRt = 1'b1;
  endtask

  typedef struct {
    logic [4:0] d_rs, d_rt; logic use_rs, use_rt;
    logic [4:0] e_rd; logic e_wreg, e_load;
    logic [4:0] m_rd; logic m_wreg;
    logic [4:0] w_rd; logic w_wreg;
    logic [1:0] exp_a, exp_b;
  } fwd_vec_t;
  fwd_vec_t vecs[8];

  initial begin
    vecs[0] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b10, 2'b00};
    vecs[1] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b01, 2'b00};
    vecs[2] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b0, 5'd5, 1'b1, 2'b11, 2'b00};
    vecs[3] = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 2'b00, 2'b00};
    vecs[4] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 2'b00, 2'b00};
    vecs[5] = '{5'd5, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 2'b00, 2'b00};
    vecs[6] = '{5'd9, 5'd7, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 5'd7, 1'b1, 5'd9, 1'b1, 2'b11, 2'b01};
    vecs[7] = '{5'd5, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'b00, 2'b10};
    for (int k = 0; k < 2; k++) begin m_left[k] = 0; m_cnt[k] = 0; end

    // Reset with busy inputs: every output must read 0.
    idle_inputs();
    Clrn = 1'b0; D_Rs = 5'd4; D_UseRs = 1'b1; E_Rd = 5'd4; E_Wreg = 1'b1;
    M_Mem = 1'b1; Mem_Ready = 1'b0; Jump = 1'b1; Br_Taken = 1'b1;
    settle();
    chk("reset_outs_a", 32'(act_vec[0]), 32'd0);
    chk("reset_count_a", act_cnt[0], 32'd0);
    tick();
    drain_clear();

    // Forwarding table.
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      D_Rs = vecs[i].d_rs; D_Rt = vecs[i].d_rt;
      D_UseRs = vecs[i].use_rs; D_UseRt = vecs[i].use_rt;
      E_Rd = vecs[i].e_rd; E_Wreg = vecs[i].e_wreg; E_Load = vecs[i].e_load;
      M_Rd = vecs[i].m_rd; M_Wreg = vecs[i].m_wreg;
      W_Rd = vecs[i].w_rd; W_Wreg = vecs[i].w_wreg;
      settle();
      chk($sformatf("fwdA_vec%0d", i), 32'(a_fwda), 32'(vecs[i].exp_a));
      chk($sformatf("fwdB_vec%0d", i), 32'(a_fwdb), 32'(vecs[i].exp_b));
      tick();
    end
    drain_clear();

    // Load-use, single bubble (instance B), then forward from M.
    load_use_rt3();
    settle();
    chk("t2_stall_b", 32'(b_stall), 32'd1);
    chk("t2_bubble_b", 32'(b_bubble), 32'd1);
    tick();
    idle_inputs();
    D_Rt = 5'd3; D_UseRt = 1'b1; M_Rd = 5'd3; M_Wreg = 1'b1; M_Mem = 1'b1;
    settle();
    chk("t2_release_b", 32'(b_stall), 32'd0);
    chk("t2_fwdB_b", 32'(b_fwdb), 32'd1);
    chk("t2_count_b", 32'(b_cnt), 32'd1);
    tick();
    drain_clear();

    // Load-use, three bubbles (instance A).
    for (int i = 0; i < 5; i++) begin
      if (i == 0) load_use_rt3(); else idle_inputs();
      settle();
      chk($sformatf("t3_stall_c%0d", i), 32'(a_stall), (i < 3) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t3_count_a", 32'(a_cnt), 32'd3);
    drain_clear();

    // Same, with a 2-cycle freeze inserted mid-sequence.
    for (int i = 0; i < 7; i++) begin
      if (i == 0) load_use_rt3(); else idle_inputs();
      if (i == 2 || i == 3) begin M_Mem = 1'b1; Mem_Ready = 1'b0; end
      settle();
      chk($sformatf("t3f_freeze_c%0d", i), 32'(a_freeze), (i == 2 || i == 3) ? 32'd1 : 32'd0);
      chk($sformatf("t3f_busy_c%0d", i), 32'(a_stall | a_freeze), (i < 5) ? 32'd1 : 32'd0);
      tick();
    end
    chk("t3f_count_a", 32'(a_cnt), 32'd5);
    drain_clear();

    // Branch during a load-use stall.
    load_use_rt3();
    settle(); tick();
    idle_inputs(); Br_Taken = 1'b1;
    settle();
    chk("t4_flush_a", 32'({a_fd, a_fe, a_fm}), 32'd7);
    chk("t4_stall_a", 32'(a_stall), 32'd0);
    tick();
    idle_inputs();
    settle();
    chk("t4_run_a", 32'(a_stall), 32'd0);
    tick();
    drain_clear();

    // Branch deferred by freeze.
    for (int i = 0; i < 5; i++) begin
      idle_inputs(); Br_Taken = 1'b1; M_Mem = 1'b1;
      Mem_Ready = (i == 4) ? 1'b1 : 1'b0;
      settle();
      chk($sformatf("t5_freeze_c%0d", i), 32'(a_freeze), (i < 4) ? 32'd1 : 32'd0);
      chk($sformatf("t5_flush_c%0d", i), 32'({a_fd, a_fe, a_fm}), (i < 4) ? 32'd0 : 32'd7);
      tick();
    end
    drain_clear();

    // Counter saturation, clear, and reset in the middle of LDUSE.
    for (int i = 0; i < 20; i++) begin
      idle_inputs(); M_Mem = 1'b1; Mem_Ready = 1'b0;
      settle(); tick();
    end
    chk("t6_sat_a", 32'(a_cnt), 32'd15);
    chk("t6_nosat_b", 32'(b_cnt), 32'd20);
    idle_inputs(); Clr_Cnt = 1'b1;
    settle(); tick();
    chk("t6_clr_a", 32'(a_cnt), 32'd0);
    load_use_rt3();
    settle(); tick();
    load_use_rt3(); Clrn = 1'b0; Jump = 1'b1; M_Mem = 1'b1; Mem_Ready = 1'b0;
    D_Rs = 5'd6; D_UseRs = 1'b1; W_Rd = 5'd6; W_Wreg = 1'b1;
    settle();
    chk("t6_rst_outs_a", 32'(act_vec[0]), 32'd0);
    chk("t6_rst_count_a", 32'(a_cnt), 32'd0);
    tick();
    idle_inputs();
    settle();
    chk("t6_after_rst_a", 32'(a_stall), 32'd0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      Clrn      = ($urandom_range(0, 99) != 0);
      D_Rs      = 5'($urandom_range(0, 3));
      D_Rt      = 5'($urandom_range(0, 3));
      D_UseRs   = 1'($urandom_range(0, 1));
      D_UseRt   = 1'($urandom_range(0, 1));
      E_Rd      = 5'($urandom_range(0, 3));
      E_Wreg    = 1'($urandom_range(0, 1));
      E_Load    = ($urandom_range(0, 2) == 0);
      M_Rd      = 5'($urandom_range(0, 3));
      M_Wreg    = 1'($urandom_range(0, 1));
      M_Mem     = 1'($urandom_range(0, 1));
      W_Rd      = 5'($urandom_range(0, 3));
      W_Wreg    = 1'($urandom_range(0, 1));
      Mem_Ready = ($urandom_range(0, 4) != 0);
      Br_Taken  = ($urandom_range(0, 9) == 0);
      Jump      = ($urandom_range(0, 6) == 0);
      Clr_Cnt   = ($urandom_range(0, 29) == 0);
      settle();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
